cordic_ci_master: RTL and testbench

CORDIC_CI_MASTER -- requirements
Module: cordic_ci_master

---
 rtl/cordic_ci_master.sv | 168 ++++++++++++++++
 tb/tb_cordic_ci_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ci_master.sv
// ---------------------------------------------------------------------------
// cordic_ci_master
//
// Feeds a stream of IEEE-754 single samples into a pipelined accumulate
// custom instruction (CI), one issue per accepted sample. It then flushes the
// CI pipeline for LATENCY cycles and captures the batch sum. The sum is held
// on the m_* side until the downstream consumer takes it.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   upstream sample stream (valid/ready)
//   ci_clk_en, ci_start  CI clock enable and issue strobe
//   ci_dataa             sample operand (zero when not issuing)
//   ci_datab             bit0 = accumulator restart flag (zero when not issuing)
//   ci_result, ci_done   CI outputs (ci_done is not needed functionally)
//   m_valid/m_data/m_count/m_ready  batch result (valid/ready)
//   busy                 high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module cordic_ci_master #(
    parameter int LATENCY = 17,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             ci_clk_en,
    output logic             ci_start,
    output logic [31:0]      ci_dataa,
    output logic [31:0]      ci_datab,
    input  logic [31:0]      ci_result,
    input  logic             ci_done,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic [CNT_W-1:0] m_count,
    input  logic             m_ready,
    output logic             busy
);

    localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DRN_W-1:0]   r_drain;
    logic [CNT_W-1:0]   r_count;
    logic               r_m_valid;
    logic [31:0]        r_m_data;

    logic               w_ready;
    logic               w_accept;
    logic               w_first;
    logic               w_drain_en;
    logic               w_drain_done;

    // The CI completion flag carries no information we need: the drain
    // counter already knows exactly when the sum is valid.
    logic               w_unused;
    assign w_unused = ci_done;

    // Next-state and per-cycle strobes. Reset forces every strobe low so the
    // CI sees no activity in a reset cycle, whatever the inputs are doing.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_first      = 1'b0;
        w_drain_en   = 1'b0;
        w_drain_done = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    w_ready  = 1'b1;
                    w_accept = s_valid;
                    w_first  = s_valid;
                    if (s_valid) begin
                        w_state_next = s_last ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    w_ready  = 1'b1;
                    w_accept = s_valid;
                    if (s_valid && s_last) begin
                        w_state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    // Clock the CI with empty slots so the last sample
                    // works its way through to ci_result.
                    w_drain_en = 1'b1;
                    if (r_drain == '0) begin
                        w_drain_done = 1'b1;
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drain   <= '0;
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_count <= CNT_W'(1);
                end else if (r_count != CNT_MAX) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            // Loading LATENCY-1 on the last issue makes the count hit zero
            // exactly LATENCY cycles after that issue.
            if (w_accept && s_last) begin
                r_drain <= DRN_W'(LATENCY - 1);
            end else if (w_drain_en && (r_drain != '0)) begin
                r_drain <= r_drain - DRN_W'(1);
            end

            if (w_drain_done) begin
                r_m_valid <= 1'b1;
                r_m_data  <= ci_result;
            end else if ((r_state == HOLD) && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // Sample path is combinational so an accepted sample issues in the
    // same cycle it is accepted.
    assign s_ready   = w_ready;
    assign ci_start  = w_accept;
    assign ci_clk_en = w_accept | w_drain_en;
    assign ci_dataa  = w_accept ? s_data : 32'd0;
    assign ci_datab  = {31'd0, w_first};

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_count = r_count;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_cordic_ci_master.sv
// ---------------------------------------------------------------------------
// tb_cordic_ci_master
//
// Drives random sample batches into cordic_ci_master. A stand-in pipelined
// integer accumulator plays the role of the custom instruction. For every
// batch the driver pushes the expected sum, count and result cycle into a
// scoreboard. A monitor pops that entry when m_valid rises and compares.
// CNT_W is reduced to 3 so that count saturation can be reached cheaply.
// ---------------------------------------------------------------------------
module tb_cordic_ci_master;

    localparam int LAT  = 17;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic          ci_clk_en;
    logic          ci_start;
    logic [31:0]   ci_dataa;
    logic [31:0]   ci_datab;
    logic [31:0]   ci_result;
    logic          ci_done;
    logic          m_valid;
    logic [31:0]   m_data;
    logic [CW-1:0] m_count;
    logic          m_ready;
    logic          busy;

    cordic_ci_master #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .ci_clk_en(ci_clk_en),
        .ci_start (ci_start),
        .ci_dataa (ci_dataa),
        .ci_datab (ci_datab),
        .ci_result(ci_result),
        .ci_done  (ci_done),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_count  (m_count),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Stand-in CI: a frozen-when-disabled pipeline of LAT-1 stages followed by
    // an accumulator, so an issue reaches ci_result after LAT enabled edges.
    logic        pv [LAT-1];
    logic        pr [LAT-1];
    logic [31:0] pd [LAT-1];
    logic [31:0] acc;
    assign ci_result = acc;
    assign ci_done   = pv[LAT-2];

    always @(posedge clock) begin
        if (reset) begin
            acc <= 32'd0;
            for (int i = 0; i < LAT-1; i++) begin
                pv[i] <= 1'b0;
                pr[i] <= 1'b0;
                pd[i] <= 32'd0;
            end
        end else if (ci_clk_en) begin
            if (pv[LAT-2]) acc <= pr[LAT-2] ? pd[LAT-2] : acc + pd[LAT-2];
            for (int i = LAT-2; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
                pd[i] <= pd[i-1];
            end
            pv[0] <= ci_start;
            pr[0] <= ci_datab[0];
            pd[0] <= ci_dataa;
        end
    end

    // Scoreboard
    logic [31:0] exp_sum [$];
    int          exp_cnt [$];
    int          exp_cyc [$];

    int hs_cycle = 0;
    bit have_hs  = 1'b0;

    // m_ready responder: hold_len == 0 ties m_ready high; otherwise m_ready is
    // random while no result is pending and rises after hold_len HOLD cycles.
    int hold_len = 0;
    int hold_ctr = 0;
    always begin
        @(posedge clock);
        #1;
        hold_ctr = m_valid ? hold_ctr + 1 : 0;
        if (hold_len == 0) m_ready = 1'b1;
        else if (m_valid)  m_ready = (hold_ctr > hold_len);
        else               m_ready = 1'($urandom_range(0, 1));
    end

    // Monitor
    bit          prev_mv = 1'b0;
    logic [31:0] h_data;
    logic [CW-1:0] h_cnt;
    always @(negedge clock) begin
        if (reset) begin
            check("rst_ci_start", 32'(ci_start), 32'd0);
            check("rst_ci_clk_en", 32'(ci_clk_en), 32'd0);
            check("rst_ci_dataa", ci_dataa, 32'd0);
            check("rst_ci_datab", ci_datab, 32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd0);
            prev_mv = 1'b0;
        end else begin
            if (!ci_start) begin
                check("noissue_dataa", ci_dataa, 32'd0);
                check("noissue_datab", ci_datab, 32'd0);
            end
            if (m_valid && !prev_mv) begin
                if (exp_sum.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_m_valid: got m_valid=1 required 0 (no batch pending, cycle %0d)", cyc);
                end else begin
                    check("m_data", m_data, exp_sum.pop_front());
                    check("m_count", 32'(m_count), 32'(exp_cnt.pop_front()));
                    check("m_valid_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
                    $display("result: m_data=%08h m_count=%0d cycle=%0d", m_data, m_count, cyc);
                end
                h_data = m_data;
                h_cnt  = m_count;
            end else if (m_valid) begin
                check("hold_m_data", m_data, h_data);
                check("hold_m_count", 32'(m_count), 32'(h_cnt));
                check("hold_s_ready", 32'(s_ready), 32'd0);
                check("hold_clk_en", 32'(ci_clk_en), 32'd0);
            end
            if (m_valid && m_ready) begin
                hs_cycle = cyc;
                have_hs  = 1'b1;
            end
            prev_mv = m_valid;
        end
    end

    // Driver: one batch of n samples with `gap` idle cycles between samples.
    task automatic send_batch(input int n, input int gap, input bit push);
        logic [31:0] sum;
        int waited;
        int wait_start;
        bit ok;
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_last  = (i == n-1);
            wait_start = cyc;
            waited = 0;
            ok = 1'b0;
            while (!ok && waited < 300) begin
                @(negedge clock);
                if (s_ready) ok = 1'b1;
                else begin
                    @(posedge clock);
                    #1;
                    waited++;
                end
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got no s_ready in 300 cycles required acceptance");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            check("issue_ci_start", 32'(ci_start), 32'd1);
            check("issue_ci_clk_en", 32'(ci_clk_en), 32'd1);
            check("issue_ci_dataa", ci_dataa, s_data);
            check("issue_ci_datab", ci_datab, (i == 0) ? 32'd1 : 32'd0);
            if (i == 0 && have_hs) begin
                if (wait_start <= hs_cycle)
                    check("first_issue_after_hold", 32'(cyc), 32'(hs_cycle + 1));
                else
                    check("first_issue_after_hold", 32'(cyc > hs_cycle), 32'd1);
            end
            sum = sum + s_data;
            $display("issue: sample %0d/%0d data=%08h datab=%0d cycle=%0d", i+1, n, ci_dataa, ci_datab[0], cyc);
            if (i == n-1 && push) begin
                exp_sum.push_back(sum);
                exp_cnt.push_back((n > CMAX) ? CMAX : n);
                exp_cyc.push_back(cyc + LAT + 1);
            end
            @(posedge clock);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = $urandom;
            if (i < n-1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clock);
                    check("gap_ci_clk_en", 32'(ci_clk_en), 32'd0);
                    check("gap_ci_start", 32'(ci_start), 32'd0);
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy || exp_sum.size() != 0) && t < 500) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_timeout: got busy=%0d pending=%0d required idle", busy, exp_sum.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", m_data, 32'd0);
        check("reset_m_count", 32'(m_count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        @(posedge clock);
        #1;

        // Four back-to-back samples, m_ready tied high
        hold_len = 0;
        send_batch(4, 0, 1);
        wait_done();

        // Three samples with 2-cycle gaps
        send_batch(3, 2, 1);
        wait_done();

        // Single-sample batch
        send_batch(1, 0, 1);
        wait_done();

        // Result held for 5 cycles while the next batch waits upstream
        hold_len = 5;
        send_batch(2, 0, 1);
        send_batch(3, 1, 1);
        wait_done();

        // Count saturation
        hold_len = 0;
        send_batch(9, 0, 1);
        wait_done();

        // Reset in the 8th DRAIN cycle abandons the batch
        send_batch(3, 0, 0);
        repeat (7) @(posedge clock);
        #1;
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = $urandom;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clock);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_m_count", 32'(m_count), 32'd0);
        check("postrst_m_valid", 32'(m_valid), 32'd0);
        repeat (30) @(posedge clock);
        #1;
        send_batch(2, 1, 1);
        wait_done();

        // Two consecutive batches with m_ready tied high
        send_batch(2, 0, 1);
        send_batch(2, 0, 1);
        wait_done();

        // Random batches
        for (int k = 0; k < 6; k++) begin
            hold_len = $urandom_range(0, 3);
            send_batch($urandom_range(1, 10), $urandom_range(0, 2), 1);
            if ($urandom_range(0, 1) == 1) wait_done();
        end
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
